// File: rtl/rt_pkg.sv
// Shared constants and types for the RT pixel scheduler and its raster counter.
package rt_pkg;

   localparam int unsigned H_RES_DEF = 640;
   localparam int unsigned V_RES_DEF = 480;
   localparam int unsigned PIX_W_DEF = 4;

   localparam int unsigned X_W    = 10;
   localparam int unsigned Y_W    = 9;
   localparam int unsigned ADDR_W = 19;

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      WAIT_LOW,
      WAIT_HIGH,
      WRITE,
      ADVANCE,
      DONE
   } sched_state_t;

endpackage

// File: rtl/rt_raster_counter.sv
// Row-major raster position (X, Y) plus its linear frame-buffer address.
// The address is kept as a running count so no multiplier is needed.
module rt_raster_counter
   import rt_pkg::*;
#(
   parameter int unsigned H_RES = H_RES_DEF,
   parameter int unsigned V_RES = V_RES_DEF
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_clear,
   input  logic              i_step,
   output logic [X_W-1:0]    o_x,
   output logic [Y_W-1:0]    o_y,
   output logic [ADDR_W-1:0] o_addr,
   output logic              o_last
);

   logic [X_W-1:0]    r_x;
   logic [Y_W-1:0]    r_y;
   logic [ADDR_W-1:0] r_addr;
   logic              w_eol;
   logic              w_eof;

   assign w_eol = (r_x == X_W'(H_RES - 1));
   assign w_eof = (r_y == Y_W'(V_RES - 1));

   // Advance one pixel per step; wrap X at end of line, wrap everything at end of frame.
   always_ff @(posedge i_clk) begin
      if (i_reset || i_clear) begin
         r_x    <= '0;
         r_y    <= '0;
         r_addr <= '0;
      end else if (i_step) begin
         if (w_eol) begin
            r_x <= '0;
            r_y <= w_eof ? '0 : r_y + 1'b1;
         end else begin
            r_x <= r_x + 1'b1;
         end
         r_addr <= (w_eol && w_eof) ? '0 : r_addr + 1'b1;
      end
   end

   assign o_x    = r_x;
   assign o_y    = r_y;
   assign o_addr = r_addr;
   assign o_last = w_eol && w_eof;

endmodule

// File: rtl/rt_pixel_scheduler.sv
// Rasters one frame through a single RT core: issue (X, Y), wait for the
// result, write it to the frame buffer, advance. All outputs are registered.
module rt_pixel_scheduler
   import rt_pkg::*;
#(
   parameter int unsigned H_RES   = H_RES_DEF,
   parameter int unsigned V_RES   = V_RES_DEF,
   parameter int unsigned PIX_W   = PIX_W_DEF,
   parameter int unsigned TIMEOUT = 4096
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_start,
   output logic              o_busy,
   output logic              o_frame_done,
   output logic              o_error,
   output logic              o_core_enable,
   output logic [X_W-1:0]    o_core_x,
   output logic [Y_W-1:0]    o_core_y,
   input  logic              i_core_ready,
   input  logic [PIX_W-1:0]  i_core_pixel,
   output logic              o_fb_we,
   output logic [ADDR_W-1:0] o_fb_addr,
   output logic [PIX_W-1:0]  o_fb_data,
   input  logic              i_fb_ready
);

   localparam int unsigned TMR_W = $clog2(TIMEOUT + 1);

   sched_state_t      r_state, w_state_next;
   logic              r_busy, w_busy_next;
   logic              r_done, w_done_next;
   logic              r_error, w_error_next;
   logic              r_en, w_en_next;
   logic [X_W-1:0]    r_core_x, w_core_x_next;
   logic [Y_W-1:0]    r_core_y, w_core_y_next;
   logic              r_fb_we, w_fb_we_next;
   logic [ADDR_W-1:0] r_fb_addr, w_fb_addr_next;
   logic [PIX_W-1:0]  r_fb_data, w_fb_data_next;
   logic [TMR_W-1:0]  r_timer, w_timer_next;

   logic              w_cnt_clear;
   logic              w_cnt_step;
   logic [X_W-1:0]    w_cnt_x;
   logic [Y_W-1:0]    w_cnt_y;
   logic [ADDR_W-1:0] w_cnt_addr;
   logic              w_cnt_last;
   logic              w_timeout;

   rt_raster_counter #(
      .H_RES (H_RES),
      .V_RES (V_RES)
   ) u_raster (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_clear (w_cnt_clear),
      .i_step  (w_cnt_step),
      .o_x     (w_cnt_x),
      .o_y     (w_cnt_y),
      .o_addr  (w_cnt_addr),
      .o_last  (w_cnt_last)
   );

   // Job timer reaches its limit on the last allowed wait cycle.
   assign w_timeout = (r_timer == TMR_W'(TIMEOUT - 1));

   // Next-state and next-output logic for the job handshake.
   always_comb begin
      w_state_next   = r_state;
      w_busy_next    = r_busy;
      w_done_next    = 1'b0;
      w_error_next   = r_error;
      w_en_next      = 1'b0;
      w_core_x_next  = r_core_x;
      w_core_y_next  = r_core_y;
      w_fb_we_next   = r_fb_we;
      w_fb_addr_next = r_fb_addr;
      w_fb_data_next = r_fb_data;
      w_timer_next   = r_timer;
      w_cnt_clear    = 1'b0;
      w_cnt_step     = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (i_start) begin
               w_error_next = 1'b0;
               w_cnt_clear  = 1'b1;
               w_busy_next  = 1'b1;
               w_state_next = ISSUE;
            end
         end
         ISSUE: begin
            if (i_core_ready) begin
               w_en_next     = 1'b1;
               w_core_x_next = w_cnt_x;
               w_core_y_next = w_cnt_y;
               w_timer_next  = '0;
               w_state_next  = WAIT_LOW;
            end
         end
         WAIT_LOW: begin
            // READY is still high right after enable; only its fall marks the job as started.
            if (w_timeout) begin
               w_error_next   = 1'b1;
               w_fb_we_next   = 1'b1;
               w_fb_addr_next = w_cnt_addr;
               w_fb_data_next = '0;
               w_state_next   = WRITE;
            end else begin
               w_timer_next = r_timer + 1'b1;
               if (!i_core_ready) begin
                  w_state_next = WAIT_HIGH;
               end
            end
         end
         WAIT_HIGH: begin
            // A result arriving on the final allowed cycle still wins over the timeout.
            if (i_core_ready) begin
               w_fb_we_next   = 1'b1;
               w_fb_addr_next = w_cnt_addr;
               w_fb_data_next = i_core_pixel;
               w_state_next   = WRITE;
            end else if (w_timeout) begin
               w_error_next   = 1'b1;
               w_fb_we_next   = 1'b1;
               w_fb_addr_next = w_cnt_addr;
               w_fb_data_next = '0;
               w_state_next   = WRITE;
            end else begin
               w_timer_next = r_timer + 1'b1;
            end
         end
         WRITE: begin
            if (i_fb_ready) begin
               w_fb_we_next = 1'b0;
               w_state_next = ADVANCE;
            end
         end
         ADVANCE: begin
            if (w_cnt_last) begin
               w_done_next  = 1'b1;
               w_busy_next  = 1'b0;
               w_state_next = DONE;
            end else begin
               w_cnt_step   = 1'b1;
               w_state_next = ISSUE;
            end
         end
         DONE: begin
            w_state_next = IDLE;
         end
         default: begin
            w_state_next = IDLE;
         end
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state   <= IDLE;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_error   <= 1'b0;
         r_en      <= 1'b0;
         r_core_x  <= '0;
         r_core_y  <= '0;
         r_fb_we   <= 1'b0;
         r_fb_addr <= '0;
         r_fb_data <= '0;
         r_timer   <= '0;
      end else begin
         r_state   <= w_state_next;
         r_busy    <= w_busy_next;
         r_done    <= w_done_next;
         r_error   <= w_error_next;
         r_en      <= w_en_next;
         r_core_x  <= w_core_x_next;
         r_core_y  <= w_core_y_next;
         r_fb_we   <= w_fb_we_next;
         r_fb_addr <= w_fb_addr_next;
         r_fb_data <= w_fb_data_next;
         r_timer   <= w_timer_next;
      end
   end

   assign o_busy        = r_busy;
   assign o_frame_done  = r_done;
   assign o_error       = r_error;
   assign o_core_enable = r_en;
   assign o_core_x      = r_core_x;
   assign o_core_y      = r_core_y;
   assign o_fb_we       = r_fb_we;
   assign o_fb_addr     = r_fb_addr;
   assign o_fb_data     = r_fb_data;

endmodule

// File: tb/tb_rt_pixel_scheduler.sv
// Bench for rt_pixel_scheduler on a 4x3 frame with TIMEOUT=16, driven by a
// behavioural RT core (pixel = X^Y) and a stallable frame-buffer port.
module tb_rt_pixel_scheduler;

   localparam int H = 4;
   localparam int V = 3;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        core_ready = 1'b1;
   logic [3:0]  core_pixel = 4'd0;
   logic        fb_ready = 1'b1;
   logic        o_busy, o_frame_done, o_error, o_core_enable, o_fb_we;
   logic [9:0]  o_core_x;
   logic [8:0]  o_core_y;
   logic [18:0] o_fb_addr;
   logic [3:0]  o_fb_data;

   rt_pixel_scheduler #(
      .H_RES   (H),
      .V_RES   (V),
      .PIX_W   (4),
      .TIMEOUT (16)
   ) dut (
      .i_clk         (clk),
      .i_reset       (rst),
      .i_start       (start),
      .o_busy        (o_busy),
      .o_frame_done  (o_frame_done),
      .o_error       (o_error),
      .o_core_enable (o_core_enable),
      .o_core_x      (o_core_x),
      .o_core_y      (o_core_y),
      .i_core_ready  (core_ready),
      .i_core_pixel  (core_pixel),
      .o_fb_we       (o_fb_we),
      .o_fb_addr     (o_fb_addr),
      .o_fb_data     (o_fb_data),
      .i_fb_ready    (fb_ready)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
   endtask

   always @(posedge clk) cyc++;

   // Scenario knobs
   int lat = 5;          // cycles READY stays low per job
   bit hold_extra = 0;   // core keeps READY high one extra cycle after enable
   int hang_x = -1;      // job that the core does not finish in time
   int hang_y = -1;
   int stall_addr = -1;  // FB address at which FB_READY is withheld
   int stall_left = 0;
   int exp_period = 0;   // expected enable-to-enable spacing, 0 = not checked

   // Behavioural RT core
   logic s_rst, s_en;
   int   s_x, s_y, jx, jy, core_cnt;
   bit   core_hold;

   function automatic int job_lat(input int x, input int y);
      return (x == hang_x && y == hang_y) ? 40 : lat;
   endfunction

   always @(posedge clk) begin
      s_rst = rst;
      s_en  = o_core_enable;
      s_x   = int'(o_core_x);
      s_y   = int'(o_core_y);
      #1;
      if (s_rst) begin
         core_ready = 1'b1;
         core_hold  = 0;
         core_cnt   = 0;
      end else if (s_en) begin
         jx = s_x;
         jy = s_y;
         if (hold_extra) core_hold = 1;
         else begin
            core_ready = 1'b0;
            core_cnt   = job_lat(jx, jy);
         end
      end else if (core_hold) begin
         core_hold  = 0;
         core_ready = 1'b0;
         core_cnt   = job_lat(jx, jy);
      end else if (!core_ready) begin
         core_cnt--;
         if (core_cnt == 0) begin
            core_ready = 1'b1;
            core_pixel = 4'(jx ^ jy);
         end
      end
   end

   // Frame-buffer port: withhold READY for stall_left cycles at stall_addr
   always @(posedge clk) begin
      #1;
      if (o_fb_we && stall_addr >= 0 && int'(o_fb_addr) == stall_addr && stall_left > 0) begin
         fb_ready = 1'b0;
         stall_left--;
      end else begin
         fb_ready = 1'b1;
      end
   end

   // Scoreboard: the frame is the row-major list of pixels, value X^Y, or 0 if timed out
   bit          armed = 0;
   int          job_idx, wr_idx, en_cyc, wr_cyc, done_cnt, stall_we_cnt;
   bit          cur_hung;
   bit          prev_we = 0, prev_rdy = 1, prev_err = 0, prev_busy = 0;
   logic [18:0] prev_addr = '0;
   logic [3:0]  prev_data = '0;
   int          wx, wy;

   always @(negedge clk) begin
      if (armed) begin
         if (o_core_enable) begin
            chk("en_x", int'(o_core_x), job_idx % H);
            chk("en_y", int'(o_core_y), job_idx / H);
            chk("en_during_write", int'(o_fb_we), 0);
            if (exp_period != 0 && job_idx > 0) chk("pixel_period", cyc - en_cyc, exp_period);
            cur_hung = (job_idx % H == hang_x) && (job_idx / H == hang_y);
            en_cyc   = cyc;
            job_idx++;
         end
         if (o_fb_we && !prev_we)
            chk("write_latency", cyc - en_cyc, cur_hung ? 16 : (hold_extra ? lat + 3 : lat + 2));
         if (o_fb_we && prev_we && !prev_rdy) begin
            chk("stall_addr_stable", int'(o_fb_addr), int'(prev_addr));
            chk("stall_data_stable", int'(o_fb_data), int'(prev_data));
         end
         if (o_fb_we && int'(o_fb_addr) == 6) stall_we_cnt++;
         if (o_fb_we && fb_ready) begin
            wx = wr_idx % H;
            wy = wr_idx / H;
            chk("wr_addr", int'(o_fb_addr), wy * H + wx);
            chk("wr_data", int'(o_fb_data), (wx == hang_x && wy == hang_y) ? 0 : (wx ^ wy));
            wr_idx++;
            wr_cyc = cyc;
         end
         if (o_busy && hang_x < 0) chk("error_low", int'(o_error), 0);
         if (o_error && !prev_err) chk("error_delay", cyc - en_cyc, 16);
         if (o_frame_done) begin
            chk("done_after_write", cyc - wr_cyc, 2);
            chk("done_busy_low", int'(o_busy), 0);
            chk("busy_before_done", int'(prev_busy), 1);
            chk("done_write_count", wr_idx, H * V);
            done_cnt++;
         end
      end
      prev_we   = o_fb_we;
      prev_rdy  = fb_ready;
      prev_err  = o_error;
      prev_busy = o_busy;
      prev_addr = o_fb_addr;
      prev_data = o_fb_data;
   end

   task automatic begin_frame(input int l, input bit hold, input int hx, input int hy);
      lat          = l;
      hold_extra   = hold;
      hang_x       = hx;
      hang_y       = hy;
      job_idx      = 0;
      wr_idx       = 0;
      en_cyc       = 0;
      wr_cyc       = 0;
      done_cnt     = 0;
      stall_we_cnt = 0;
      cur_hung     = 0;
      exp_period   = 0;
      armed        = 1;
   endtask

   task automatic pulse_start();
      @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      chk("start_busy", int'(o_busy), 1);
      chk("start_error_cleared", int'(o_error), 0);
   endtask

   task automatic wait_done(input int budget);
      bit seen;
      seen = 0;
      for (int i = 0; i < budget && !seen; i++) begin
         @(negedge clk);
         if (o_frame_done) seen = 1;
      end
      chk("frame_done_seen", int'(seen), 1);
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, "_busy"}, int'(o_busy), 0);
      chk({tag, "_frame_done"}, int'(o_frame_done), 0);
      chk({tag, "_error"}, int'(o_error), 0);
      chk({tag, "_core_enable"}, int'(o_core_enable), 0);
      chk({tag, "_core_x"}, int'(o_core_x), 0);
      chk({tag, "_core_y"}, int'(o_core_y), 0);
      chk({tag, "_fb_we"}, int'(o_fb_we), 0);
      chk({tag, "_fb_addr"}, int'(o_fb_addr), 0);
      chk({tag, "_fb_data"}, int'(o_fb_data), 0);
   endtask

   bit pulsing;
   bit found;

   initial begin
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      check_reset_vals("reset");

      // A: latency 5 -> first FB_WE 7 cycles after enable
      begin_frame(5, 0, -1, -1);
      pulse_start();
      wait_done(1000);

      // B: READY held one cycle past enable, latency 3 -> write 6 cycles after enable
      begin_frame(3, 1, -1, -1);
      pulse_start();
      wait_done(1000);

      // C: FB_READY low for 7 cycles at pixel (2,1) -> FB_WE high 8 cycles at address 6
      begin_frame(2, 0, -1, -1);
      stall_addr = 6;
      stall_left = 7;
      pulse_start();
      wait_done(1000);
      chk("stall_we_cycles", stall_we_cnt, 8);
      stall_addr = -1;

      // D: core hangs at (1,0) -> ERROR 16 cycles after enable, zero written at address 1
      begin_frame(2, 0, 1, 0);
      pulse_start();
      wait_done(2000);
      chk("error_sticky", int'(o_error), 1);

      // E: fastest case, 1-cycle core, FB always ready -> one pixel every 6 cycles
      begin_frame(1, 0, -1, -1);
      exp_period = 6;
      pulse_start();
      wait_done(1000);

      // F: reset while waiting for the core at (3,2), then a clean restart
      begin_frame(5, 0, -1, -1);
      pulse_start();
      found = 0;
      for (int i = 0; i < 500 && !found; i++) begin
         @(negedge clk);
         if (o_core_enable && int'(o_core_x) == 3 && int'(o_core_y) == 2) found = 1;
      end
      chk("reach_pixel_3_2", int'(found), 1);
      @(posedge clk);
      @(posedge clk);
      #1;
      armed = 0;
      rst   = 1'b1;
      @(posedge clk);
      #1;
      check_reset_vals("midreset");
      rst = 1'b0;
      repeat (2) @(posedge clk);
      begin_frame(5, 0, -1, -1);
      pulse_start();
      wait_done(1000);

      // G: START pulses during a frame are ignored
      begin_frame(5, 0, -1, -1);
      pulse_start();
      pulsing = 1;
      fork
         begin
            while (pulsing) begin
               repeat (9) @(posedge clk);
               #1;
               if (pulsing && o_busy) begin
                  start = 1'b1;
                  @(posedge clk);
                  #1 start = 1'b0;
               end
            end
         end
         begin
            wait_done(1000);
            pulsing = 0;
         end
      join
      repeat (30) @(posedge clk);
      #1;
      chk("single_frame_done", done_cnt, 1);
      chk("frame_writes", wr_idx, 12);
      chk("idle_after_frame", int'(o_busy), 0);
      armed = 0;

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got cycle %0d, expected end", cyc);
      $fatal(1, "watchdog");
   end

endmodule
